frame_buffer_mp: RTL



---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_ram_bank.sv | 59 +++++
 rtl/frame_buffer_mp.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_pkg : shared defaults, clear-FSM state type and frame-size helper       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fb_pkg;

  localparam int          c_def_h_res    = 160;
  localparam int          c_def_v_res    = 120;
  localparam int          c_def_dw       = 12;
  localparam logic [11:0] c_def_bg_color = 12'h000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  function automatic int fb_npos(input int h, input int v);
    return h * v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_ram_bank : NPOS x DW frame RAM, one write port, two registered reads    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_ram_bank #(
  parameter int    DW        = 12,
  parameter int    NPOS      = 19200,
  parameter int    AW        = 15,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ra_en,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic          rb_en,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
);

  localparam int c_iw = (NPOS > 1) ? $clog2(NPOS) : 1;

  logic [DW-1:0]   r_mem [0:NPOS-1];
  logic [DW-1:0]   r_ra_q;
  logic [DW-1:0]   r_rb_q;
  logic [c_iw-1:0] w_widx;
  logic [c_iw-1:0] w_aidx;
  logic [c_iw-1:0] w_bidx;

  assign w_widx = waddr[c_iw-1:0];
  assign w_aidx = ra_addr[c_iw-1:0];
  assign w_bidx = rb_addr[c_iw-1:0];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[w_widx] <= wdata;
    end
  end

  // Nonblocking reads give read-before-write on a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ra_q <= '0;
      r_rb_q <= '0;
    end else begin
      if (ra_en) r_ra_q <= r_mem[w_aidx];
      if (rb_en) r_rb_q <= r_mem[w_bidx];
    end
  end

  assign ra_data = r_ra_q;
  assign rb_data = r_rb_q;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_buffer_mp : frame memory with capture write, VGA and proc read ports |
// | and a clear engine. Option macro: FRAME_BUFFER_DOUBLE_BUF_EN (2 banks).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_buffer_mp
  import fb_pkg::*;
#(
  parameter int            H_RES     = c_def_h_res,
  parameter int            V_RES     = c_def_v_res,
  parameter int            DW        = c_def_dw,
  parameter int            AW        = 15,
  parameter logic [DW-1:0] BG_COLOR  = DW'(c_def_bg_color),
  parameter string         INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  input  logic          proc_req,
  input  logic [AW-1:0] proc_addr,
  output logic [DW-1:0] proc_data,
  output logic          proc_valid,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          frame_done,
  output logic          rd_bank
);

  localparam int            c_npos     = fb_npos(H_RES, V_RES);
  localparam logic [AW:0]   c_npos_ext = (AW+1)'(c_npos);
  localparam logic [AW-1:0] c_last     = AW'(c_npos - 1);

  if ((64'd1 << AW) < 64'(c_npos)) begin : g_aw_check
    $fatal(1, "frame_buffer_mp: 2**AW must be >= H_RES*V_RES");
  end

  fb_state_t     r_state;
  fb_state_t     w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          w_wr_ok;
  logic          w_vga_ok;
  logic          w_proc_ok;
  logic          w_bank_we;
  logic [AW-1:0] w_bank_addr;
  logic [DW-1:0] w_bank_data;
  logic          r_vga_oob;
  logic          r_proc_oob;
  logic          r_proc_valid;
  logic [DW-1:0] w_vga_q;
  logic [DW-1:0] w_proc_q;

  assign w_wr_ok   = {1'b0, wr_addr}   < c_npos_ext;
  assign w_vga_ok  = {1'b0, vga_addr}  < c_npos_ext;
  assign w_proc_ok = {1'b0, proc_addr} < c_npos_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_clr_cnt <= (r_clr_cnt == c_last) ? '0 : r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clr_start)            w_state_nxt = CLEAR;
      CLEAR:   if (r_clr_cnt == c_last)  w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  // The clear engine owns the write port while busy; capture writes are dropped.
  always_comb begin
    clr_busy    = 1'b0;
    w_bank_we   = wr_en & w_wr_ok;
    w_bank_addr = wr_addr;
    w_bank_data = wr_data;
    if (r_state == CLEAR) begin
      clr_busy    = 1'b1;
      w_bank_we   = 1'b1;
      w_bank_addr = r_clr_cnt;
      w_bank_data = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vga_oob    <= 1'b0;
      r_proc_oob   <= 1'b0;
      r_proc_valid <= 1'b0;
    end else begin
      r_vga_oob    <= ~w_vga_ok;
      r_proc_valid <= proc_req;
      if (proc_req) r_proc_oob <= ~w_proc_ok;
    end
  end

`ifdef FRAME_BUFFER_DOUBLE_BUF_EN
  logic          r_rd_bank;
  logic          r_vga_sel;
  logic          r_proc_sel;
  logic [DW-1:0] w_vga_q0;
  logic [DW-1:0] w_vga_q1;
  logic [DW-1:0] w_proc_q0;
  logic [DW-1:0] w_proc_q1;

  // Select registers capture the front bank at read issue, so a swap only
  // affects reads issued after the frame_done edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_bank  <= 1'b0;
      r_vga_sel  <= 1'b0;
      r_proc_sel <= 1'b0;
    end else begin
      if (frame_done) r_rd_bank <= ~r_rd_bank;
      r_vga_sel <= r_rd_bank;
      if (proc_req) r_proc_sel <= r_rd_bank;
    end
  end

  fb_ram_bank #(.DW(DW), .NPOS(c_npos), .AW(AW), .INIT_FILE(INIT_FILE)) u_bank0 (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (w_bank_we & r_rd_bank),
    .waddr   (w_bank_addr),
    .wdata   (w_bank_data),
    .ra_en   (w_vga_ok),
    .ra_addr (vga_addr),
    .ra_data (w_vga_q0),
    .rb_en   (proc_req & w_proc_ok),
    .rb_addr (proc_addr),
    .rb_data (w_proc_q0)
  );

  fb_ram_bank #(.DW(DW), .NPOS(c_npos), .AW(AW), .INIT_FILE("")) u_bank1 (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (w_bank_we & ~r_rd_bank),
    .waddr   (w_bank_addr),
    .wdata   (w_bank_data),
    .ra_en   (w_vga_ok),
    .ra_addr (vga_addr),
    .ra_data (w_vga_q1),
    .rb_en   (proc_req & w_proc_ok),
    .rb_addr (proc_addr),
    .rb_data (w_proc_q1)
  );

  assign w_vga_q  = r_vga_sel  ? w_vga_q1  : w_vga_q0;
  assign w_proc_q = r_proc_sel ? w_proc_q1 : w_proc_q0;
  assign rd_bank  = r_rd_bank;
`else
  logic w_unused_frame_done;

  assign w_unused_frame_done = frame_done;

  fb_ram_bank #(.DW(DW), .NPOS(c_npos), .AW(AW), .INIT_FILE(INIT_FILE)) u_bank0 (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (w_bank_we),
    .waddr   (w_bank_addr),
    .wdata   (w_bank_data),
    .ra_en   (w_vga_ok),
    .ra_addr (vga_addr),
    .ra_data (w_vga_q),
    .rb_en   (proc_req & w_proc_ok),
    .rb_addr (proc_addr),
    .rb_data (w_proc_q)
  );

  assign rd_bank = 1'b0;
`endif

  assign vga_data   = r_vga_oob  ? BG_COLOR : w_vga_q;
  assign proc_data  = r_proc_oob ? BG_COLOR : w_proc_q;
  assign proc_valid = r_proc_valid;

endmodule
`default_nettype wire
